flag_ctrl: RTL and testbench

Controller that owns the CPU's architectural carry/sign/zero flags (cf, sf, zf) and decides who writes them each cycle. It arbitrates between ALU flag updates, explicit flag instructions (set/clear/complement) and interrupt context restore. It keeps a small save stack for interrupt entry/exit and evaluates branch condition codes with a registered result for the control unit.

---
 rtl/flag_ctrl_pkg.sv | 44 ++++
 rtl/flag_ctrl_if.sv | 41 ++++
 rtl/flag_ctrl_stack.sv | 57 +++++
 rtl/flag_ctrl.sv | 85 ++++++++
 tb/tb_flag_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flag_ctrl_pkg.sv
// Shared flag-controller definitions: flag bit order {cf,sf,zf}, flag-op and
// condition-code encodings, and the branch condition evaluator.
package flag_ctrl_pkg;

  typedef logic [2:0] flags_t;

  localparam int FLAG_CF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_ZF = 0;

  typedef enum logic [1:0] {
    FOP_NOP = 2'b00,
    FOP_SET = 2'b01,
    FOP_CLR = 2'b10,
    FOP_CPL = 2'b11
  } fop_e;

  typedef enum logic [2:0] {
    CC_AL = 3'd0,
    CC_EQ = 3'd1,
    CC_NE = 3'd2,
    CC_CS = 3'd3,
    CC_CC = 3'd4,
    CC_MI = 3'd5,
    CC_PL = 3'd6,
    CC_NV = 3'd7
  } cc_e;

  function automatic logic cond_eval(flags_t f, logic [2:0] code);
    logic res;
    case (cc_e'(code))
      CC_AL:   res = 1'b1;
      CC_EQ:   res = f[FLAG_ZF];
      CC_NE:   res = ~f[FLAG_ZF];
      CC_CS:   res = f[FLAG_CF];
      CC_CC:   res = ~f[FLAG_CF];
      CC_MI:   res = f[FLAG_SF];
      CC_PL:   res = ~f[FLAG_SF];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_ctrl_if.sv
// Flag controller request/status bundle; master drives requests, slave owns flags.
interface flag_ctrl_if;

  logic       alu_we;
  logic [2:0] alu_mask;
  logic       alu_cf;
  logic       alu_sf;
  logic       alu_zf;
  logic       fop_valid;
  logic [1:0] fop_code;
  logic [2:0] fop_mask;
  logic       push;
  logic       pop;
  logic       cond_valid;
  logic [2:0] cond_code;
  logic       cf_out;
  logic       sf_out;
  logic       zf_out;
  logic       cond_done;
  logic       cond_true;
  logic       stack_empty;
  logic       stack_full;
  logic       err;

  modport master (
    output alu_we, alu_mask, alu_cf, alu_sf, alu_zf,
    output fop_valid, fop_code, fop_mask,
    output push, pop, cond_valid, cond_code,
    input  cf_out, sf_out, zf_out, cond_done, cond_true,
    input  stack_empty, stack_full, err
  );

  modport slave (
    input  alu_we, alu_mask, alu_cf, alu_sf, alu_zf,
    input  fop_valid, fop_code, fop_mask,
    input  push, pop, cond_valid, cond_code,
    output cf_out, sf_out, zf_out, cond_done, cond_true,
    output stack_empty, stack_full, err
  );

endinterface

// File: rtl/flag_ctrl_stack.sv
// LIFO of saved flag contexts for interrupt entry/exit. Simultaneous push+pop,
// push when full and pop when empty are all rejected and reported via err_o.
module flag_ctrl_stack
  import flag_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  logic   pop_i,
  input  flags_t wdat_i,
  output flags_t rdat_o,
  output logic   pop_ok_o,
  output logic   empty_o,
  output logic   full_o,
  output logic   err_o
);

  flags_t         mem_q [DEPTH];
  logic [PTR_W:0] ptr_q;
  logic [PTR_W:0] ptr_d;
  logic           push_ok;

  assign empty_o  = (ptr_q == '0);
  assign full_o   = (ptr_q == (PTR_W+1)'(DEPTH));
  assign push_ok  = push_i & ~pop_i & ~full_o;
  assign pop_ok_o = pop_i & ~push_i & ~empty_o;
  assign err_o    = (push_i & pop_i) | (push_i & full_o) | (pop_i & empty_o);
  assign rdat_o   = mem_q[PTR_W'(ptr_q - 1'b1)];

  always_comb begin
    ptr_d = ptr_q;
    if (push_ok) begin
      ptr_d = ptr_q + 1'b1;
    end else if (pop_ok_o) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was pushed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[ptr_q[PTR_W-1:0]] <= wdat_i;
    end
  end

endmodule

// File: rtl/flag_ctrl.sv
// Owns cf/sf/zf: arbitrates stack restore > ALU > flag op, saves contexts on
// push, and evaluates branch conditions on pre-edge flags with a one-cycle pulse.
module flag_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic         clk,
  input  logic         rst,
  flag_ctrl_if.slave   bus
);

  flags_t flags_q, flags_d;
  flags_t stk_rdat;
  flags_t alu_vec;
  logic   stk_pop_ok;
  logic   stk_err;
  logic   err_q, err_d;
  logic   cond_done_q, cond_done_d;
  logic   cond_true_q, cond_true_d;

  flag_ctrl_stack #(
    .DEPTH (STACK_DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push_i   (bus.push),
    .pop_i    (bus.pop),
    .wdat_i   (flags_q),
    .rdat_o   (stk_rdat),
    .pop_ok_o (stk_pop_ok),
    .empty_o  (bus.stack_empty),
    .full_o   (bus.stack_full),
    .err_o    (stk_err)
  );

  assign alu_vec = {bus.alu_cf, bus.alu_sf, bus.alu_zf};

  // Only the winning source touches the flags; losers are dropped entirely.
  always_comb begin
    flags_d = flags_q;
    if (stk_pop_ok) begin
      flags_d = stk_rdat;
    end else if (bus.alu_we) begin
      flags_d = (flags_q & ~bus.alu_mask) | (alu_vec & bus.alu_mask);
    end else if (bus.fop_valid) begin
      case (fop_e'(bus.fop_code))
        FOP_SET: flags_d = flags_q | bus.fop_mask;
        FOP_CLR: flags_d = flags_q & ~bus.fop_mask;
        FOP_CPL: flags_d = flags_q ^ bus.fop_mask;
        default: flags_d = flags_q;
      endcase
    end
  end

  always_comb begin
    err_d       = err_q | stk_err;
    cond_done_d = bus.cond_valid;
    cond_true_d = bus.cond_valid ? cond_eval(flags_q, bus.cond_code) : cond_true_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= '0;
      err_q       <= 1'b0;
      cond_done_q <= 1'b0;
      cond_true_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      err_q       <= err_d;
      cond_done_q <= cond_done_d;
      cond_true_q <= cond_true_d;
    end
  end

  assign bus.cf_out    = flags_q[FLAG_CF];
  assign bus.sf_out    = flags_q[FLAG_SF];
  assign bus.zf_out    = flags_q[FLAG_ZF];
  assign bus.err       = err_q;
  assign bus.cond_done = cond_done_q;
  assign bus.cond_true = cond_true_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Scoreboard bench for flag_ctrl: a reference model predicts each cycle's
// outputs, directed scenarios add fixed expectations, then a random phase.
module tb_flag_ctrl;

  typedef struct packed {
    logic [2:0] fl;
    logic       cd;
    logic       ct;
    logic       emp;
    logic       ful;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  flag_ctrl_if bus ();

  flag_ctrl #(.STACK_DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  logic [2:0] m_flags;
  logic [2:0] m_stack [4];
  int         m_ptr;
  logic       m_err, m_cd, m_ct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] out_flags();
    return {bus.cf_out, bus.sf_out, bus.zf_out};
  endfunction

  task automatic idle();
    rst            = 1'b0;
    bus.alu_we     = 1'b0;
    bus.alu_mask   = 3'b000;
    bus.alu_cf     = 1'b0;
    bus.alu_sf     = 1'b0;
    bus.alu_zf     = 1'b0;
    bus.fop_valid  = 1'b0;
    bus.fop_code   = 2'b00;
    bus.fop_mask   = 3'b000;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.cond_valid = 1'b0;
    bus.cond_code  = 3'd0;
  endtask

  // Reference model: advance one clock from the currently driven inputs.
  task automatic model(output exp_t e);
    logic [2:0] pre, nf, av;
    if (rst) begin
      m_flags = 3'b000; m_ptr = 0; m_err = 1'b0; m_cd = 1'b0; m_ct = 1'b0;
    end else begin
      pre = m_flags;
      nf  = pre;
      av  = {bus.alu_cf, bus.alu_sf, bus.alu_zf};
      m_cd = bus.cond_valid;
      if (bus.cond_valid) begin
        case (bus.cond_code)
          3'd0: m_ct = 1'b1;
          3'd1: m_ct = pre[0];
          3'd2: m_ct = !pre[0];
          3'd3: m_ct = pre[2];
          3'd4: m_ct = !pre[2];
          3'd5: m_ct = pre[1];
          3'd6: m_ct = !pre[1];
          default: m_ct = 1'b0;
        endcase
      end
      if (bus.push && bus.pop) m_err = 1'b1;
      else if (bus.push && m_ptr == 4) m_err = 1'b1;
      else if (bus.pop && m_ptr == 0) m_err = 1'b1;
      if (bus.pop && !bus.push && m_ptr > 0) begin
        m_ptr = m_ptr - 1;
        nf = m_stack[m_ptr];
      end else if (bus.alu_we) begin
        for (int b = 0; b < 3; b++) if (bus.alu_mask[b]) nf[b] = av[b];
      end else if (bus.fop_valid) begin
        case (bus.fop_code)
          2'b01: nf = pre | bus.fop_mask;
          2'b10: nf = pre & ~bus.fop_mask;
          2'b11: nf = pre ^ bus.fop_mask;
          default: nf = pre;
        endcase
      end
      if (bus.push && !bus.pop && m_ptr < 4) begin
        m_stack[m_ptr] = pre;
        m_ptr = m_ptr + 1;
      end
      m_flags = nf;
    end
    e.fl  = m_flags;
    e.cd  = m_cd;
    e.ct  = m_ct;
    e.emp = (m_ptr == 0);
    e.ful = (m_ptr == 4);
    e.err = m_err;
  endtask

  task automatic step();
    exp_t e;
    model(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_flags", 32'(out_flags()), 32'(e.fl));
      chk("sb_cond_done", 32'(bus.cond_done), 32'(e.cd));
      chk("sb_cond_true", 32'(bus.cond_true), 32'(e.ct));
      chk("sb_empty", 32'(bus.stack_empty), 32'(e.emp));
      chk("sb_full", 32'(bus.stack_full), 32'(e.ful));
      chk("sb_err", 32'(bus.err), 32'(e.err));
    end
    idle();
  endtask

  task automatic alu(input logic [2:0] mask, input logic [2:0] val);
    bus.alu_we   = 1'b1;
    bus.alu_mask = mask;
    {bus.alu_cf, bus.alu_sf, bus.alu_zf} = val;
  endtask

  initial begin
    idle();
    m_flags = '0; m_ptr = 0; m_err = 0; m_cd = 0; m_ct = 0;
    for (int i = 0; i < 4; i++) m_stack[i] = '0;

    rst = 1'b1; step();
    chk("rst_flags", 32'(out_flags()), 32'd0);
    chk("rst_empty", 32'(bus.stack_empty), 32'd1);
    chk("rst_full", 32'(bus.stack_full), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    alu(3'b111, 3'b101); step();
    chk("t1_alu111", 32'(out_flags()), 32'b101);
    alu(3'b010, 3'b010); step();
    chk("t1_alu010", 32'(out_flags()), 32'b111);

    alu(3'b001, 3'b000);
    bus.fop_valid = 1'b1; bus.fop_code = 2'b01; bus.fop_mask = 3'b100;
    step();
    chk("t2_alu_wins", 32'(out_flags()), 32'b110);

    alu(3'b111, 3'b101); step();
    bus.push = 1'b1; step();
    chk("t3_push_nonempty", 32'(bus.stack_empty), 32'd0);
    bus.fop_valid = 1'b1; bus.fop_code = 2'b10; bus.fop_mask = 3'b111; step();
    chk("t3_clear", 32'(out_flags()), 32'b000);
    bus.pop = 1'b1; step();
    chk("t3_pop", 32'(out_flags()), 32'b101);
    chk("t3_empty", 32'(bus.stack_empty), 32'd1);

    for (int i = 0; i < 4; i++) begin
      bus.push = 1'b1;
      alu(3'b111, 3'(i + 1));
      step();
    end
    chk("t4_full", 32'(bus.stack_full), 32'd1);
    chk("t4_err_before", 32'(bus.err), 32'd0);
    bus.push = 1'b1; step();
    chk("t4_push_full_err", 32'(bus.err), 32'd1);
    chk("t4_still_full", 32'(bus.stack_full), 32'd1);
    chk("t4_flags_kept", 32'(out_flags()), 32'b100);
    begin
      logic [2:0] lifo [4];
      lifo[0] = 3'b011; lifo[1] = 3'b010; lifo[2] = 3'b001; lifo[3] = 3'b101;
      for (int i = 0; i < 4; i++) begin
        bus.pop = 1'b1; step();
        chk($sformatf("t4_pop%0d", i), 32'(out_flags()), 32'(lifo[i]));
      end
    end
    chk("t4_empty", 32'(bus.stack_empty), 32'd1);
    bus.pop = 1'b1; step();
    chk("t4_pop_empty_flags", 32'(out_flags()), 32'b101);
    chk("t4_pop_empty_err", 32'(bus.err), 32'd1);

    alu(3'b111, 3'b001); step();
    alu(3'b001, 3'b000);
    bus.cond_valid = 1'b1; bus.cond_code = 3'd1; step();
    chk("t5_eq_done", 32'(bus.cond_done), 32'd1);
    chk("t5_eq_pre", 32'(bus.cond_true), 32'd1);
    chk("t5_zf_cleared", 32'(bus.zf_out), 32'd0);
    bus.cond_valid = 1'b1; bus.cond_code = 3'd2; step();
    chk("t5_ne_done", 32'(bus.cond_done), 32'd1);
    chk("t5_ne_true", 32'(bus.cond_true), 32'd1);
    bus.cond_valid = 1'b1; bus.cond_code = 3'd7; step();
    chk("t5_nv_true", 32'(bus.cond_true), 32'd0);
    step();
    chk("t5_done_drop", 32'(bus.cond_done), 32'd0);

    bus.push = 1'b1; bus.pop = 1'b1; alu(3'b100, 3'b100); step();
    chk("t6_cf", 32'(bus.cf_out), 32'd1);
    chk("t6_ptr", 32'(bus.stack_empty), 32'd1);
    chk("t6_err", 32'(bus.err), 32'd1);
    rst = 1'b1; bus.cond_valid = 1'b1; alu(3'b111, 3'b111); step();
    chk("t6_rst_flags", 32'(out_flags()), 32'd0);
    chk("t6_rst_err", 32'(bus.err), 32'd0);
    chk("t6_rst_done", 32'(bus.cond_done), 32'd0);
    chk("t6_rst_empty", 32'(bus.stack_empty), 32'd1);

    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 59) == 0);
      bus.alu_we     = ($urandom_range(0, 2) == 0);
      bus.alu_mask   = 3'($urandom);
      {bus.alu_cf, bus.alu_sf, bus.alu_zf} = 3'($urandom);
      bus.fop_valid  = ($urandom_range(0, 1) == 0);
      bus.fop_code   = 2'($urandom);
      bus.fop_mask   = 3'($urandom);
      bus.push       = ($urandom_range(0, 3) == 0);
      bus.pop        = ($urandom_range(0, 3) == 0);
      bus.cond_valid = ($urandom_range(0, 1) == 0);
      bus.cond_code  = 3'($urandom);
      step();
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
